ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- Synthesizable single-slave AHB-Lite memory responder.
- Sits directly downstream of the testbench AHB master interface and acts as the DUT it drives.
- Decodes address/data pipelined transfers, inserts a configurable number of wait states, and stores or returns word/halfword/byte data.
- Answers illegal transfers with the two-cycle AHB ERROR response.

Parameters:
- ADDR_WIDTH, 32, haddr width (matches ahb_pkg AHB_ADDR_WIDTH).
- DATA_WIDTH, 32, hwdata/hrdata width. Only 32 is supported.
- MEM_DEPTH, 256, number of 32-bit words. Must be a power of 2.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase. Legal range 0..7.
- BASE_ADDR, 0, byte address of word 0. Must be aligned to MEM_DEPTH*4.

Ports:
- hclk  in  1  bus clock; all flops on posedge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address (address phase).
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  0=byte, 1=half, 2=word.
- hburst  in  3  ignored; every beat is treated independently.
- hprot  in  4  ignored.
- hmastlock  in  1  ignored.
- hwdata  in  DATA_WIDTH  write data (data phase).
- hready  in  1  bus-level ready; a phase completes when hready=1.
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  DATA_WIDTH  read data, valid when hreadyout=1 in a read data phase.

Behaviour:
- Reset (async, hreset=1): hreadyout=1, hresp=0, hrdata=0, state=IDLE, captured phase cleared. Memory contents are not reset.
- Address phase is accepted on a posedge with hsel=1, hready=1 and htrans[1]=1. Accepting registers haddr, hwrite and hsize.
- IDLE or BUSY transfers, or hsel=0, get a zero-wait OKAY and cause no access.
- A transfer is illegal if any of the following holds: address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4), hsize>2, or misalignment (half with haddr[0]=1; word with haddr[1:0]!=0).
- States:
  - IDLE: no data phase pending. Legal accept goes to WAIT if WAIT_STATES>0, else DATA. Illegal accept goes to ERR1.
  - WAIT: hreadyout=0, hresp=0. A down-counter loaded with WAIT_STATES moves to DATA after WAIT_STATES cycles.
  - DATA: hreadyout=1, hresp=0. A new address phase may be accepted in this same cycle (pipelined back-to-back); the next state follows the IDLE rules.
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. Any address phase presented here is accepted and follows the IDLE rules.
- Write: at the posedge ending DATA, bytes selected by hsize and the captured addr[1:0] are written from the matching hwdata lanes.
- Read: hrdata is registered and valid throughout DATA. Unselected byte lanes return the full word contents.
- hrdata is held between transfers and does not update during ERR1/ERR2.
- Read-after-write forwarding: if a write commits on the same edge that loads read data for the same word, merged write bytes are forwarded. Back-to-back W then R to the same address at WAIT_STATES=0 returns the new data.
- Counter width is 3 bits. It never wraps, because WAIT_STATES is at most 7.
- Reset asserted mid-transfer aborts the transfer: no memory write, and outputs go to reset values immediately.

Decomposition:
- ahb_pkg holds:
  - htrans constants: IDLE_HTRANS, BUSY_HTRANS, NONSEQ_HTRANS, SEQ_HTRANS.
  - hsize constants: H8_SIZE, H16_SIZE, H32_SIZE.
  - hresp constants: OKAY_HRESP, ERROR_HRESP.
  - ahb_slv_state_e enum: IDLE, WAIT, DATA, ERR1, ERR2.
- One sub-module, ahb_mem_array, contains the byte-enabled word RAM with the read-port forwarding mux. The FSM, decode and counter stay in ahb_slave_mem.

Test Plan:
- WAIT_STATES=0: NONSEQ write word 0x10 = 0xDEADBEEF, then read 0x10 -> hreadyout never low; read data phase hrdata=0xDEADBEEF, hresp=0.
- WAIT_STATES=2: single write then read -> hreadyout low for exactly 2 cycles in each data phase; read returns the written value.
- Byte writes 0xAA at 0x21 and half 0x1234 at 0x22 over word 0x20=0 -> read word 0x20 = 0x1234AA00.
- Read at 0x400 (MEM_DEPTH=256) and word read at 0x03 -> each gives cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1; memory unchanged.
- Back-to-back W 0x40=0x55AA55AA then R 0x40 pipelined at WAIT_STATES=0 -> hrdata=0x55AA55AA (forwarding).
- hreset pulsed during WAIT of a write to 0x08 holding 0x11111111 -> outputs return to reset values; a later read of 0x08 returns 0x11111111.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type for the memory responder.
package ahb_pkg;

    localparam logic [1:0] IDLE_HTRANS   = 2'b00;
    localparam logic [1:0] BUSY_HTRANS   = 2'b01;
    localparam logic [1:0] NONSEQ_HTRANS = 2'b10;
    localparam logic [1:0] SEQ_HTRANS    = 2'b11;

    localparam logic [2:0] H8_SIZE  = 3'd0;
    localparam logic [2:0] H16_SIZE = 3'd1;
    localparam logic [2:0] H32_SIZE = 3'd2;

    localparam logic OKAY_HRESP  = 1'b0;
    localparam logic ERROR_HRESP = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } ahb_slv_state_e;

    // Byte-lane enables for a transfer of the given size at the given byte lane.
    function automatic logic [3:0] size_to_be(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            H8_SIZE:  be = 4'b0001 << lane;
            H16_SIZE: be = lane[1] ? 4'b1100 : 4'b0011;
            H32_SIZE: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between one master and the memory slave.
interface ahb_slave_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_mem_array.sv
// Byte-enabled word RAM. The read port returns the stored word with any bytes
// being written on the same edge merged in, so a read loaded on the commit edge
// of a write to the same word sees the new data.
module ahb_mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [3:0]       i_wr_be,
    input  logic [31:0]      i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_word
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] w_stored;
    logic        w_fwd_hit;

    // Commit enabled byte lanes of the write word; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read mux with same-word write forwarding per byte lane.
    always_comb begin
        w_stored  = r_mem[i_rd_idx];
        w_fwd_hit = i_wr_en && (i_wr_idx == i_rd_idx);
        o_rd_word = w_stored;
        for (int b = 0; b < 4; b++) begin
            o_rd_word[8*b +: 8] = (w_fwd_hit && i_wr_be[b]) ? i_wr_data[8*b +: 8]
                                                             : w_stored[8*b +: 8];
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite single-slave memory responder: address decode, wait-state counter,
// two-cycle ERROR response and registered read data.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic            hclk,
    input  logic            hreset,
    ahb_slave_mem_if.slave  bus
);

    localparam int unsigned           LP_IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_BASE  = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LP_SPAN  = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

    ahb_slv_state_e          r_state;
    logic [2:0]              r_cnt;
    logic [LP_IDX_W-1:0]     r_idx;
    logic [1:0]              r_lane;
    logic                    r_hwrite;
    logic [2:0]              r_hsize;
    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [DATA_WIDTH-1:0]   r_hrdata;

    logic [ADDR_WIDTH:0]     w_offset;
    logic                    w_in_range;
    logic                    w_misalign;
    logic                    w_illegal;
    logic [LP_IDX_W-1:0]     w_idx;
    logic                    w_accept;
    logic                    w_slot;
    logic                    w_take;
    logic                    w_end_wait;
    logic                    w_wr_en;
    logic [3:0]              w_wr_be;
    logic [LP_IDX_W-1:0]     w_rd_idx;
    logic                    w_load_rd;
    logic [31:0]             w_rd_word;
    logic                    w_unused;

    // Offset from the base wraps to a huge value below the base, so one compare covers both bounds.
    assign w_offset   = {1'b0, bus.haddr} - LP_BASE;
    assign w_in_range = (w_offset < LP_SPAN);
    assign w_misalign = ((bus.hsize == H16_SIZE) && bus.haddr[0]) ||
                        ((bus.hsize == H32_SIZE) && (bus.haddr[1:0] != 2'b00));
    assign w_illegal  = !w_in_range || (bus.hsize > H32_SIZE) || w_misalign;
    assign w_idx      = w_offset[LP_IDX_W+1:2];

    assign w_accept   = bus.hsel && bus.hready && bus.htrans[1];
    assign w_slot     = (r_state == IDLE) || (r_state == DATA) || (r_state == ERR2);
    assign w_take     = w_accept && w_slot;
    assign w_end_wait = (r_state == WAIT) && (r_cnt == 3'd1);

    assign w_wr_en    = (r_state == DATA) && r_hwrite;
    assign w_wr_be    = size_to_be(r_hsize, r_lane);
    assign w_rd_idx   = (r_state == WAIT) ? r_idx : w_idx;

    assign w_unused   = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

    // Decide whether read data is loaded on this edge (entering a read DATA phase).
    always_comb begin
        w_load_rd = 1'b0;
        if (w_take && !w_illegal && !bus.hwrite && (WAIT_STATES == 32'd0)) begin
            w_load_rd = 1'b1;
        end else if (w_end_wait && !r_hwrite) begin
            w_load_rd = 1'b1;
        end else begin
            w_load_rd = 1'b0;
        end
    end

    // Transfer FSM with wait counter, phase capture and registered handshake outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_idx       <= '0;
            r_lane      <= 2'b00;
            r_hwrite    <= 1'b0;
            r_hsize     <= 3'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= OKAY_HRESP;
        end else begin
            case (r_state)
                WAIT: begin
                    if (w_end_wait) begin
                        r_state     <= DATA;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= OKAY_HRESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ERR1: begin
                    r_state     <= ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= ERROR_HRESP;
                end
                IDLE, DATA, ERR2: begin
                    if (w_take) begin
                        r_idx    <= w_idx;
                        r_lane   <= bus.haddr[1:0];
                        r_hwrite <= bus.hwrite;
                        r_hsize  <= bus.hsize;
                        if (w_illegal) begin
                            r_state     <= ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= ERROR_HRESP;
                        end else if (WAIT_STATES != 32'd0) begin
                            r_state     <= WAIT;
                            r_cnt       <= 3'(WAIT_STATES);
                            r_hreadyout <= 1'b0;
                            r_hresp     <= OKAY_HRESP;
                        end else begin
                            r_state     <= DATA;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= OKAY_HRESP;
                        end
                    end else begin
                        r_state     <= IDLE;
                        r_hwrite    <= 1'b0;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= OKAY_HRESP;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_hwrite    <= 1'b0;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= OKAY_HRESP;
                end
            endcase
        end
    end

    // Read data register: loads only when a read DATA phase begins, held otherwise.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_hrdata <= '0;
        end else if (w_load_rd) begin
            r_hrdata <= w_rd_word;
        end
    end

    ahb_mem_array #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (LP_IDX_W)
    ) u_mem (
        .i_clk     (hclk),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_be   (w_wr_be),
        .i_wr_data (bus.hwdata),
        .i_rd_idx  (w_rd_idx),
        .o_rd_word (w_rd_word)
    );

    assign bus.hreadyout = r_hreadyout;
    assign bus.hresp     = r_hresp;
    assign bus.hrdata    = r_hrdata;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: two instances (0 and 2 wait states) behind
// a shared master model, read data checked through an expected-value queue.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_slave_mem_if if0 ();
    ahb_slave_mem_if if2 ();

    logic        sel;
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;

    assign if0.hsel = m_hsel & ~sel;
    assign if2.hsel = m_hsel & sel;
    assign if0.haddr = m_haddr;   assign if2.haddr = m_haddr;
    assign if0.htrans = m_htrans; assign if2.htrans = m_htrans;
    assign if0.hwrite = m_hwrite; assign if2.hwrite = m_hwrite;
    assign if0.hsize = m_hsize;   assign if2.hsize = m_hsize;
    assign if0.hwdata = m_hwdata; assign if2.hwdata = m_hwdata;
    assign if0.hburst = 3'b000;   assign if2.hburst = 3'b000;
    assign if0.hprot = 4'b0011;   assign if2.hprot = 4'b0011;
    assign if0.hmastlock = 1'b0;  assign if2.hmastlock = 1'b0;
    assign if0.hready = if0.hreadyout;
    assign if2.hready = if2.hreadyout;

    logic        o_rdy;
    logic        o_resp;
    logic [31:0] o_rdata;
    assign o_rdy   = sel ? if2.hreadyout : if0.hreadyout;
    assign o_resp  = sel ? if2.hresp     : if0.hresp;
    assign o_rdata = sel ? if2.hrdata    : if0.hrdata;

    ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (.hclk(hclk), .hreset(hreset), .bus(if0));
    ahb_slave_mem #(.WAIT_STATES(2)) u_dut2 (.hclk(hclk), .hreset(hreset), .bus(if2));

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q [$];
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        m_hsel   = 1'b0;
        m_htrans = IDLE_HTRANS;
        m_hwrite = 1'b0;
        m_hsize  = H32_SIZE;
        m_haddr  = 32'h0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        check({tag, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check({tag, " rdata"}, o_rdata, exp);
            last_rd = exp;
        end
    endtask

    // One non-pipelined transfer: address phase, data phase (with wait/err checks), back to idle.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic err, input int exp_waits);
        int n;
        m_hsel   = 1'b1;
        m_htrans = NONSEQ_HTRANS;
        m_hwrite = wr;
        m_hsize  = size;
        m_haddr  = addr;
        if (!wr && !err) sb_q.push_back(exp_rd);
        @(posedge hclk); #1;
        go_idle();
        if (wr) m_hwdata = wdata;
        if (err) begin
            check({tag, " err1_rdy"}, 32'(o_rdy), 32'd0);
            check({tag, " err1_resp"}, 32'(o_resp), 32'd1);
            @(posedge hclk); #1;
            check({tag, " err2_rdy"}, 32'(o_rdy), 32'd1);
            check({tag, " err2_resp"}, 32'(o_resp), 32'd1);
            check({tag, " err_hold"}, o_rdata, last_rd);
        end else begin
            n = 0;
            while (o_rdy !== 1'b1 && n < 16) begin
                @(posedge hclk); #1;
                n++;
            end
            check({tag, " waits"}, 32'(n), 32'(exp_waits));
            check({tag, " resp"}, 32'(o_resp), 32'd0);
            if (!wr) pop_check(tag);
        end
        @(posedge hclk); #1;
    endtask

    initial begin
        hreset   = 1'b1;
        sel      = 1'b0;
        m_hwdata = 32'h0;
        last_rd  = 32'h0;
        go_idle();
        repeat (2) @(posedge hclk);
        #1;
        check("rst0_rdy", 32'(if0.hreadyout), 32'd1);
        check("rst0_resp", 32'(if0.hresp), 32'd0);
        check("rst0_rdata", if0.hrdata, 32'h0);
        check("rst2_rdy", 32'(if2.hreadyout), 32'd1);
        check("rst2_rdata", if2.hrdata, 32'h0);
        hreset = 1'b0;
        @(posedge hclk); #1;

        // Zero wait states: word, byte and halfword traffic.
        xfer("w10",  1'b1, 32'h10, H32_SIZE, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        xfer("r10",  1'b0, 32'h10, H32_SIZE, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        xfer("rb11", 1'b0, 32'h11, H8_SIZE,  32'h0, 32'hDEADBEEF, 1'b0, 0);
        xfer("w20",  1'b1, 32'h20, H32_SIZE, 32'h00000000, 32'h0, 1'b0, 0);
        xfer("wb21", 1'b1, 32'h21, H8_SIZE,  32'h0000AA00, 32'h0, 1'b0, 0);
        xfer("wh22", 1'b1, 32'h22, H16_SIZE, 32'h12340000, 32'h0, 1'b0, 0);
        xfer("r20",  1'b0, 32'h20, H32_SIZE, 32'h0, 32'h1234AA00, 1'b0, 0);

        // Illegal transfers get the two-cycle ERROR and leave memory alone.
        xfer("w00",  1'b1, 32'h00,  H32_SIZE, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        xfer("e400", 1'b0, 32'h400, H32_SIZE, 32'h0, 32'h0, 1'b1, 0);
        xfer("e03",  1'b0, 32'h03,  H32_SIZE, 32'h0, 32'h0, 1'b1, 0);
        xfer("ew02", 1'b1, 32'h02,  H32_SIZE, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        xfer("eh01", 1'b1, 32'h01,  H16_SIZE, 32'h0000FFFF, 32'h0, 1'b1, 0);
        xfer("esz3", 1'b1, 32'h00,  3'd3,     32'h77777777, 32'h0, 1'b1, 0);
        xfer("r00",  1'b0, 32'h00,  H32_SIZE, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        // Pipelined write then read of the same word: read must see the new data.
        m_hsel = 1'b1; m_htrans = NONSEQ_HTRANS; m_hwrite = 1'b1; m_hsize = H32_SIZE; m_haddr = 32'h40;
        @(posedge hclk); #1;
        check("b2b_wdata_rdy", 32'(o_rdy), 32'd1);
        m_hwdata = 32'h55AA55AA;
        m_hwrite = 1'b0;
        sb_q.push_back(32'h55AA55AA);
        @(posedge hclk); #1;
        go_idle();
        check("b2b_rdy", 32'(o_rdy), 32'd1);
        check("b2b_resp", 32'(o_resp), 32'd0);
        pop_check("b2b");
        @(posedge hclk); #1;
        xfer("r40", 1'b0, 32'h40, H32_SIZE, 32'h0, 32'h55AA55AA, 1'b0, 0);

        // Two wait states.
        sel = 1'b1;
        last_rd = 32'h0;
        xfer("w30", 1'b1, 32'h30, H32_SIZE, 32'h0BADC0DE, 32'h0, 1'b0, 2);
        xfer("r30", 1'b0, 32'h30, H32_SIZE, 32'h0, 32'h0BADC0DE, 1'b0, 2);

        // BUSY and unselected transfers must not start a data phase.
        m_hsel = 1'b1; m_htrans = BUSY_HTRANS; m_haddr = 32'h30;
        @(posedge hclk); #1;
        check("busy_rdy", 32'(o_rdy), 32'd1);
        check("busy_resp", 32'(o_resp), 32'd0);
        m_hsel = 1'b0; m_htrans = NONSEQ_HTRANS;
        @(posedge hclk); #1;
        check("nosel_rdy", 32'(o_rdy), 32'd1);
        go_idle();
        @(posedge hclk); #1;

        xfer("e2_401", 1'b0, 32'h401, H32_SIZE, 32'h0, 32'h0, 1'b1, 0);

        // Reset during the WAIT phase of a write aborts it.
        xfer("w08", 1'b1, 32'h08, H32_SIZE, 32'h11111111, 32'h0, 1'b0, 2);
        m_hsel = 1'b1; m_htrans = NONSEQ_HTRANS; m_hwrite = 1'b1; m_hsize = H32_SIZE; m_haddr = 32'h08;
        @(posedge hclk); #1;
        go_idle();
        m_hwdata = 32'h22222222;
        check("rstw_wait_rdy", 32'(o_rdy), 32'd0);
        #2 hreset = 1'b1;
        #1;
        check("rstw_rdy", 32'(o_rdy), 32'd1);
        check("rstw_resp", 32'(o_resp), 32'd0);
        check("rstw_rdata", o_rdata, 32'h0);
        last_rd = 32'h0;
        @(posedge hclk); #2;
        hreset = 1'b0;
        @(posedge hclk); #1;
        xfer("r08", 1'b0, 32'h08, H32_SIZE, 32'h0, 32'h11111111, 1'b0, 2);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
